// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: PS/2 pins in, decoded scan-code events out.
// master = receiver, slave = pin driver / game-logic consumer.
interface ps2_keyboard_rx_if;
    logic       keyclk;
    logic       keyinput;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;
    logic       busy;

    modport master (
        input  keyclk,
        input  keyinput,
        output code,
        output code_valid,
        output is_break,
        output is_extended,
        output frame_err,
        output busy
    );

    modport slave (
        output keyclk,
        output keyinput,
        input  code,
        input  code_valid,
        input  is_break,
        input  is_extended,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: filtered PS/2 deframer with scan-code event strobe.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into flags.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_keyboard_rx_if.master  bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Index 0 is keyclk, index 1 is keyinput.
    logic [1:0]    pin_raw;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];

    logic          clk_q;
    logic          fall;
    logic          din;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_ok;

    logic [7:0]    code_q;
    logic          valid_q;
    logic          err_q;
`ifdef PS2_PREFIX_DECODE_EN
    logic          brk_q;
    logic          ext_q;
    logic          brk_p;
    logic          ext_p;
`endif

    assign pin_raw = {bus.keyinput, bus.keyclk};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= pin_raw;
            sync_b <= sync_a;
        end
    end

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt    <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == F_LAST) begin
                    filt[i] <= sync_b[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_q <= 1'b1;
        end else begin
            clk_q <= filt[0];
        end
    end

    assign fall     = clk_q & ~filt[0];
    assign din      = filt[1];
    assign timeout  = (state != S_IDLE) && (to_cnt == T_END) && !fall;
    assign frame_ok = din & (^{shreg, par_bit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (fall || state == S_IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != T_END) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            brk_p   <= 1'b0;
            ext_p   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (timeout) begin
                state   <= S_IDLE;
                bit_cnt <= 3'd0;
                shreg   <= 8'h00;
                err_q   <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                brk_p   <= 1'b0;
                ext_p   <= 1'b0;
`endif
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!din) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= din;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!frame_ok) begin
                            err_q <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                            brk_p <= 1'b0;
                            ext_p <= 1'b0;
`endif
                        end else begin
`ifdef PS2_PREFIX_DECODE_EN
                            if (shreg == 8'hE0) begin
                                ext_p <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk_p <= 1'b1;
                            end else begin
                                code_q  <= shreg;
                                brk_q   <= brk_p;
                                ext_q   <= ext_p;
                                valid_q <= 1'b1;
                                brk_p   <= 1'b0;
                                ext_p   <= 1'b0;
                            end
`else
                            code_q  <= shreg;
                            valid_q <= 1'b1;
`endif
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = (state != S_IDLE);
`ifdef PS2_PREFIX_DECODE_EN
    assign bus.is_break    = brk_q;
    assign bus.is_extended = ext_q;
`else
    assign bus.is_break    = 1'b0;
    assign bus.is_extended = 1'b0;
`endif

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver directly upstream of the VGA game controller.
- Takes the raw keyclk/keyinput pins, filters them, deframes 11-bit PS/2 frames and folds E0/F0 prefixes into flags.
- Presents one scan-code event per key make/break to the game logic as a single-cycle strobe.
- Host-to-device transmission is not supported; the block is receive-only.

Parameters:
- FILTER_LEN, 8: number of consecutive identical clk samples required before the filtered keyclk/keyinput level changes.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered keyclk falling edge before a partial frame is aborted (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic is in this domain.
- rst  input  1  asynchronous, active-high reset.
- keyclk  input  1  PS/2 clock pin; asynchronous to clk.
- keyinput  input  1  PS/2 data pin; asynchronous to clk.
- code  output  8  last decoded scan code, with prefixes removed.
- code_valid  output  1  one-cycle strobe: code, is_break and is_extended are updated this cycle.
- is_break  output  1  code was preceded by F0 (key release).
- is_extended  output  1  code was preceded by E0.
- frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout error.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: code=0x00, code_valid=0, is_break=0, is_extended=0, frame_err=0, busy=0. Filtered keyclk/keyinput=1. Prefix flags cleared. State=IDLE.
- Input conditioning: 2-flop synchroniser on each pin, then a FILTER_LEN saturating-counter glitch filter.
  - The filtered level changes only after FILTER_LEN consecutive equal samples.
- Falling-edge detect: registered filtered keyclk; fall = previous 1 and current 0. All bit sampling uses filtered keyinput on the fall cycle.
- FSM states and transitions:
  - IDLE: on fall with data=0 (start bit) go to DATA with bit count=0. On fall with data=1, stay in IDLE; no error is raised.
  - DATA: shift data in LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on fall, return to IDLE and evaluate the frame.
    - Frame valid = stop bit is 1 and (popcount(data)+parity) is odd.
    - If invalid: pulse frame_err on the cycle after the stop-bit fall, clear the prefix flags, and do not assert code_valid.
- Byte handling for a valid byte, registered one cycle after the stop-bit fall:
  - 0xE0: set ext_pending. No strobe.
  - 0xF0: set brk_pending. No strobe.
  - Any other byte: code=byte, is_extended=ext_pending, is_break=brk_pending, code_valid=1 for one cycle. Clear both pending flags the same cycle.
- Output hold: code, is_break and is_extended hold their values until the next code_valid.
- Timeout: counter resets on every fall and counts while state != IDLE.
  - On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear the shift register and the prefix flags.
  - The counter saturates; it does not wrap.
- Simultaneous events: timeout expiry on the same cycle as a fall — the fall wins and the counter resets.
- Reset mid-frame: the partial frame is discarded, pending flags are lost, and no strobe is issued.
- Back-to-back frames: IDLE accepts a start-bit fall immediately after the STOP fall. No dead time is required beyond the PS/2 timing itself.

Optional Feature:
- Macro: PS2_PREFIX_DECODE_EN.
- Defined: E0/F0 handling as described above.
- Undefined:
  - Every valid byte, including 0xE0 and 0xF0, produces code_valid with code=raw byte.
  - is_break and is_extended are tied to 0.
  - The pending-flag logic is removed.

Test Plan:
- Frame 0x1C, sent as bits 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity 0, stop), 20 µs half-period → one code_valid with code=0x1C, is_break=0, is_extended=0; frame_err never asserts.
- Frames F0 then 1C → exactly one code_valid, with code=0x1C and is_break=1. A following 1C strobes with is_break=0.
- Frames E0, F0, 74 → one code_valid: code=0x74, is_extended=1, is_break=1. No strobe for E0 or F0.
- Frame 0x1C with parity=1 → one frame_err pulse and no code_valid. A following valid 0x29 strobes with code=0x29, is_break=0.
- Stop keyclk after 5 bits, then wait TIMEOUT_CYCLES+10 cycles → frame_err pulses once and busy drops. A following clean 0x29 frame decodes correctly.
- Glitch and reset cases:
  - keyclk low glitch of FILTER_LEN-2 cycles in IDLE → busy stays 0 and no output changes.
  - Assert rst mid-frame after F0 → all outputs return to reset values. A next 1C gives is_break=0.
